// File: rtl/matmul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : matmul_sequencer
// Description : Sequencer for C = A x B on NxN 9-bit minifloat matrices.
//               Buffers A and B, issues one multiply/accumulate step per
//               cycle to an external combinational multiplier and adder,
//               then streams C out row-major with valid/ready handshake.
//               Optional macro MATMUL_SEQ_CYCLE_CNT_EN adds a 16-bit
//               saturating busy-cycle counter on port cycle_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_sequencer #(
  parameter int N = 2,
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] mul_a,
  output logic [W-1:0] mul_b,
  input  logic [W-1:0] mul_out,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  input  logic [W-1:0] add_sum,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
`ifdef MATMUL_SEQ_CYCLE_CNT_EN
  output logic [15:0]  cycle_cnt,
`endif
  output logic         done
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Operand and result buffers; contents are don't-care after reset.
  logic [W-1:0] a_mem [N][N];
  logic [W-1:0] b_mem [N][N];
  logic [W-1:0] c_mem [N][N];

  // Load position: matrix select (0=A, 1=B), row, column.
  logic          ld_mat;
  logic [IW-1:0] ld_row, ld_col;

  // Compute loop indices (i outer, j middle, k inner).
  logic [IW-1:0] ci, cj, ck;

  // Output position.
  logic [IW-1:0] oi, oj;

  logic [W-1:0] acc;

  logic load_fire, load_last, step_last, out_fire, out_last, start_ok;

  // Bit 8 is reserved: it is ignored on every input word and driven 0.
  function automatic logic [W-1:0] clean(input logic [W-1:0] x);
    return {1'b0, x[W-2:0]};
  endfunction

  logic unused_bits;
  assign unused_bits = ^{in_data[W-1], mul_out[W-1], add_sum[W-1]};

  assign start_ok  = (state == IDLE) && start && !done;
  assign load_fire = (state == LOAD) && in_valid;
  assign load_last = load_fire && ld_mat && (ld_row == LAST) && (ld_col == LAST);
  assign step_last = (state == COMPUTE) && (ci == LAST) && (cj == LAST) && (ck == LAST);
  assign out_fire  = (state == OUTPUT) && out_ready;
  assign out_last  = out_fire && (oi == LAST) && (oj == LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and datapath-facing outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    out_data  = '0;
    mul_a     = '0;
    mul_b     = '0;
    add_a     = '0;
    add_b     = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start_ok) state_nxt = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (load_last) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        mul_a = a_mem[ci][ck];
        mul_b = b_mem[ck][cj];
        add_a = acc;
        add_b = clean(mul_out);
        if (step_last) state_nxt = OUTPUT;
      end
      OUTPUT: begin
        out_valid = 1'b1;
        out_data  = c_mem[oi][oj];
        if (out_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Load position counter: column, then row, then A->B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_mat <= 1'b0;
      ld_row <= '0;
      ld_col <= '0;
    end else if (state == IDLE) begin
      ld_mat <= 1'b0;
      ld_row <= '0;
      ld_col <= '0;
    end else if (load_fire) begin
      if (ld_col == LAST) begin
        ld_col <= '0;
        if (ld_row == LAST) begin
          ld_row <= '0;
          ld_mat <= ~ld_mat;
        end else begin
          ld_row <= ld_row + IW'(1);
        end
      end else begin
        ld_col <= ld_col + IW'(1);
      end
    end
  end

  // Operand capture into A or B buffer.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      if (ld_mat) b_mem[ld_row][ld_col] <= clean(in_data);
      else        a_mem[ld_row][ld_col] <= clean(in_data);
    end
  end

  // Compute loop indices, k fastest; all wrap to 0 after the final step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ci <= '0;
      cj <= '0;
      ck <= '0;
    end else if (state == COMPUTE) begin
      if (ck == LAST) begin
        ck <= '0;
        if (cj == LAST) begin
          cj <= '0;
          ci <= (ci == LAST) ? '0 : ci + IW'(1);
        end else begin
          cj <= cj + IW'(1);
        end
      end else begin
        ck <= ck + IW'(1);
      end
    end
  end

  // Accumulator: seeded by the first product, then follows the adder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (state == COMPUTE) begin
      if (ck == '0)        acc <= clean(mul_out);
      else if (ck != LAST) acc <= clean(add_sum);
    end
  end

  // Final adder result of each inner product goes straight into C.
  always_ff @(posedge clk) begin
    if ((state == COMPUTE) && (ck == LAST)) c_mem[ci][cj] <= clean(add_sum);
  end

  // Output position advances only on an accepted result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oi <= '0;
      oj <= '0;
    end else if (out_fire) begin
      if (oj == LAST) begin
        oj <= '0;
        oi <= (oi == LAST) ? '0 : oi + IW'(1);
      end else begin
        oj <= oj + IW'(1);
      end
    end
  end

  // Done pulse in the cycle after the last result is taken; it also
  // masks a start arriving in that same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done <= 1'b0;
    else        done <= out_last;
  end

`ifdef MATMUL_SEQ_CYCLE_CNT_EN
  // Busy-cycle counter: cleared on accepted start, saturates, holds in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
    end else if (state == IDLE) begin
      if (start_ok) cycle_cnt <= '0;
    end else if (cycle_cnt != 16'hFFFF) begin
      cycle_cnt <= cycle_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_matmul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_matmul_sequencer
// Description : Self-checking bench for matmul_sequencer with add-based
//               multiplier/adder stubs and a matrix-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_sequencer;

  localparam int N  = 2;
  localparam int W  = 9;
  localparam int NN = N * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] mul_a, mul_b, mul_out;
  logic [W-1:0] add_a, add_b, add_sum;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         busy;
  logic         done;
`ifdef MATMUL_SEQ_CYCLE_CNT_EN
  logic [15:0]  cycle_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] amat [N][N];
  logic [W-1:0] bmat [N][N];

  always #5 clk = ~clk;

  // Datapath stubs: 9-bit wrapping adds.
  assign mul_out = mul_a + mul_b;
  assign add_sum = add_a + add_b;

  matmul_sequencer #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_out   (mul_out),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
`ifdef MATMUL_SEQ_CYCLE_CNT_EN
    .cycle_cnt (cycle_cnt),
`endif
    .done      (done)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: C[i][j] = sum_k A[i][k]*B[k][j] with the stub "multiply" being
  // an add; reserved bit 8 is dropped from every word, so arithmetic is mod 256.
  function automatic logic [W-1:0] model_c(input int i, input int j);
    int acc;
    int p;
    acc = 0;
    for (int k = 0; k < N; k++) begin
      p   = (int'(amat[i][k][7:0]) + int'(bmat[k][j][7:0])) % 256;
      acc = (acc + p) % 256;
    end
    return W'(acc);
  endfunction

  task automatic randomize_mats();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        amat[i][j] = W'($urandom);
        bmat[i][j] = W'($urandom);
      end
  endtask

  // One job. gap: in_valid toggles; stall: out_ready low 3 cycles per word;
  // poke: start pulsed during LOAD; sdone: start pulsed in the done cycle;
  // abort: reset asserted a few cycles into COMPUTE.
  task automatic run_job(input bit gap, input bit stall, input bit poke,
                         input bit sdone, input bit abort);
    int idx, guard, r;
    bit fire;
    logic [W-1:0] exp;
    // in_valid while idle must not load anything
    in_valid = 1'b1;
    in_data  = W'($urandom);
    #1;
    check_value("idle_in_ready", in_ready, 0);
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_value("load_busy", busy, 1);
`ifdef MATMUL_SEQ_CYCLE_CNT_EN
    check_value("cnt_cleared", cycle_cnt, 0);
`endif
    idx = 0;
    guard = 0;
    while (idx < 2 * NN && guard < 1000) begin
      in_valid = gap ? ((guard % 2) == 0) : 1'b1;
      in_data  = (idx < NN) ? amat[idx / N][idx % N] : bmat[(idx - NN) / N][(idx - NN) % N];
      if (poke && guard == 3) start = 1'b1;
      #1;
      check_value("load_in_ready", in_ready, 1);
      fire = in_valid && in_ready;
      @(negedge clk);
      start = 1'b0;
      if (fire) idx++;
      guard++;
    end
    in_valid = 1'b0;
    if (guard >= 1000) check_value("load_timeout", 0, 1);
    out_ready = stall ? 1'b0 : 1'b1;
    // compute: operand order i, j, k with exact N^3 latency
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        for (int k = 0; k < N; k++) begin
          check_value("op_mul_a", mul_a, {1'b0, amat[i][k][7:0]});
          check_value("op_mul_b", mul_b, {1'b0, bmat[k][j][7:0]});
          check_value("comp_out_valid", out_valid, 0);
          check_value("comp_in_ready", in_ready, 0);
          if (abort && i == 0 && j == 1) begin
            #2;
            rst_n = 1'b0;
            #1;
            check_value("rst_busy", busy, 0);
            check_value("rst_out_valid", out_valid, 0);
            check_value("rst_in_ready", in_ready, 0);
            check_value("rst_mul_a", mul_a, 0);
            check_value("rst_add_a", add_a, 0);
            @(negedge clk);
            rst_n = 1'b1;
            out_ready = 1'b0;
            return;
          end
          @(negedge clk);
        end
    // output stream
    for (r = 0; r < NN; r++) begin
      exp = model_c(r / N, r % N);
      if (stall) begin
        for (int s = 0; s < 3; s++) begin
          check_value("stall_valid", out_valid, 1);
          check_value("stall_data", out_data, exp);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
      #1;
      check_value("out_valid", out_valid, 1);
      check_value("out_data", out_data, exp);
      check_value("out_in_ready", in_ready, 0);
      check_value("out_no_done", done, 0);
      @(negedge clk);
      if (stall) out_ready = 1'b0;
    end
    out_ready = 1'b0;
    check_value("done_pulse", done, 1);
    check_value("done_busy", busy, 0);
    check_value("done_no_extra", out_valid, 0);
`ifdef MATMUL_SEQ_CYCLE_CNT_EN
    if (!gap && !stall) check_value("cnt_at_done", cycle_cnt, 2 * NN + N * N * N + NN);
`endif
    if (sdone) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_value("done_cleared", done, 0);
    check_value("idle_after", busy, 0);
`ifdef MATMUL_SEQ_CYCLE_CNT_EN
    if (!gap && !stall) check_value("cnt_hold", cycle_cnt, 2 * NN + N * N * N + NN);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    check_value("reset_busy", busy, 0);
    check_value("reset_in_ready", in_ready, 0);
    check_value("reset_out_valid", out_valid, 0);
    check_value("reset_done", done, 0);
    check_value("reset_mul_a", mul_a, 0);
    check_value("reset_out_data", out_data, 0);
`ifdef MATMUL_SEQ_CYCLE_CNT_EN
    check_value("reset_cnt", cycle_cnt, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    amat[0][0] = 9'd1; amat[0][1] = 9'd2; amat[1][0] = 9'd3; amat[1][1] = 9'd4;
    bmat[0][0] = 9'd5; bmat[0][1] = 9'd6; bmat[1][0] = 9'd7; bmat[1][1] = 9'd8;
    run_job(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_job(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

    randomize_mats();
    run_job(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_job(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    for (int t = 0; t < 4; t++) begin
      randomize_mats();
      run_job(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Controller that computes C = A x B for two NxN matrices of 9-bit minifloat words using one shared external multiplier and one shared external adder.
- Word format: bit 8 reserved (driven 0, ignored on input), bit 7 sign, bits 6:4 exponent (bias 3), bits 3:0 mantissa with hidden leading 1.
- The block buffers the operands, drives the multiplier and adder once per inner-product step, and streams the results out.
- It sits between the operand source/result sink and the combinational Multiplier/adder datapath.

Parameters:
- N, 2, matrix dimension; legal range 2..4.
- W, 9, word width; fixed at 9 and not overridden.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a job; ignored unless in IDLE.
- in_data  input  W  operand word.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- mul_a  output  W  multiplier operand 1 (A element).
- mul_b  output  W  multiplier operand 2 (B element).
- mul_out  input  W  combinational multiplier result.
- add_a  output  W  adder operand 1 (accumulator).
- add_b  output  W  adder operand 2 (current product, equal to mul_out).
- add_sum  input  W  combinational adder result.
- out_data  output  W  result word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  sink accepts out_data.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last result is accepted.

Behaviour:
- Reset: asserting rst_n low at any time, including mid-job, forces IDLE immediately.
  - All outputs go to 0, as do all counters and the accumulator.
  - Operand/result storage contents are don't-care after reset.
- States and transitions:
  - IDLE -> LOAD on start.
  - LOAD -> COMPUTE after 2*N*N accepted words.
  - COMPUTE -> OUTPUT after N*N*N steps.
  - OUTPUT -> IDLE after N*N accepted results, with done=1 for exactly that one cycle.
- LOAD:
  - in_ready=1 only in this state.
  - A word transfers when in_valid & in_ready.
  - Order: A row-major (A[0][0], A[0][1], ...), then B row-major.
  - Gaps in in_valid stall the load; no timeout.
- COMPUTE: one step per cycle, never stalls. Loop order is i outer, j middle, k inner. Each step:
  - mul_a=A[i][k], mul_b=B[k][j], add_a=acc, add_b=mul_out.
  - On k=0, acc <= mul_out (the adder result is ignored).
  - On 0<k<N-1, acc <= add_sum.
  - On k=N-1, the final value (add_sum) is written directly to C[i][j]; the acc register need not hold it.
  - Outside COMPUTE, mul_a/mul_b/add_a/add_b are held at 0.
- Arithmetic: none is done in the block. Rounding, overflow and saturation belong entirely to the external datapath.
- OUTPUT:
  - Results are streamed row-major.
  - out_valid stays high and out_data stays stable until out_ready; no word is dropped or duplicated.
  - out_ready while out_valid=0 is ignored.
- Latency: from the cycle after the last load beat, the first out_valid is asserted exactly N*N*N cycles later.
- Simultaneous events:
  - start during a job is ignored.
  - in_valid outside LOAD is ignored.
  - start in the same cycle as done is ignored; the block is in IDLE the next cycle and needs a new start.

Optional Feature:
- Macro: MATMUL_SEQ_CYCLE_CNT_EN.
- When defined: adds output port cycle_cnt (16 bits).
  - Cleared on start accepted in IDLE.
  - Increments every cycle while busy=1; saturates at 16'hFFFF.
  - Holds its value in IDLE; reset to 0 by rst_n.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Bench stubs for all scenarios: mul_out = mul_a + mul_b and add_sum = add_a + add_b (9-bit wrap).
- N=2, A=[1,2;3,4], B=[5,6;7,8], continuous valid/ready -> outputs 15,17,19,21 in order, then done pulse; first out_valid exactly 8 cycles after the last load beat.
- Same job with in_valid toggling every other cycle and out_ready low for 3 cycles on each result -> identical results, out_data stable while stalled, in_ready only in LOAD, no drop or duplicate.
- Check COMPUTE operand order cycle-by-cycle for the first job -> mul_a/mul_b = (1,5),(2,7),(1,6),(2,8),(3,5),(4,7),(3,6),(4,8).
- Pulse rst_n low mid-COMPUTE -> busy=0, out_valid=0, in_ready=0 immediately; a new start with a full load gives correct results.
- start asserted during LOAD, and in_valid asserted in IDLE -> both ignored, with word count and results unchanged.
- With MATMUL_SEQ_CYCLE_CNT_EN defined, run the first job with no stalls -> cycle_cnt = 8 load + 8 compute + 4 output = 20 at done; it holds 20 in IDLE and clears on the next start.
